st2mm_cpl_tracker: RTL

ST2MM_CPL_TRACKER -- requirements
Module: st2mm_cpl_tracker

---
 rtl/st2mm_pkg.sv | 39 +++
 rtl/st2mm_cpl_slot_ram.sv | 87 ++++++++
 rtl/st2mm_cpl_tracker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/st2mm_pkg.sv
// Shared types for the streaming-to-MMIO read path: AXI response codes,
// completion header info and completion status encodings.
package st2mm_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } e_resp;

  typedef struct packed {
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [11:0] byte_count;
  } t_cpl_hdr_info;

  localparam int CPL_HDR_INFO_WIDTH = $bits(t_cpl_hdr_info);

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'b00,
    SLOT_PEND = 2'b01,
    SLOT_DONE = 2'b10
  } e_slot_state;

  function automatic logic [2:0] resp_to_status(input e_resp r);
    case (r)
      RESP_SLVERR: return CPL_CA;
      RESP_DECERR: return CPL_UR;
      default:     return CPL_SC;
    endcase
  endfunction

endpackage

// File: rtl/st2mm_cpl_slot_ram.sv
// Flop-based tracker slots: allocate port, response/timeout port, retire
// port, async read at head plus a state/generation lookup for response matching.
module st2mm_cpl_slot_ram
  import st2mm_pkg::*;
#(
  parameter  int NUM_SLOTS = 8,
  parameter  int DATA_W    = 64,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_en,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  t_cpl_hdr_info      alloc_hdr,
  input  logic               alloc_gen,
  input  logic               done_en,
  input  logic [IDX_W-1:0]   done_idx,
  input  logic [2:0]         done_status,
  input  logic [DATA_W-1:0]  done_data,
  input  logic               free_en,
  input  logic [IDX_W-1:0]   free_idx,
  input  logic [IDX_W-1:0]   head_idx,
  output e_slot_state        head_state,
  output t_cpl_hdr_info      head_hdr,
  output logic [2:0]         head_status,
  output logic [DATA_W-1:0]  head_data,
  input  logic [IDX_W-1:0]   look_idx,
  output e_slot_state        look_state,
  output logic               look_gen
);

  logic [NUM_SLOTS-1:0][1:0]                    state_vec;
  logic [NUM_SLOTS-1:0]                         gen_vec;
  logic [NUM_SLOTS-1:0][CPL_HDR_INFO_WIDTH-1:0] hdr_vec;
  logic [NUM_SLOTS-1:0][2:0]                    sts_vec;
  logic [NUM_SLOTS-1:0][DATA_W-1:0]             dat_vec;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic          a_hit, d_hit, f_hit;
    e_slot_state   st_q;
    logic          gen_q;
    t_cpl_hdr_info hdr_q;
    logic [2:0]    sts_q;
    logic [DATA_W-1:0] dat_q;

    assign a_hit = alloc_en & (alloc_idx == IDX_W'(s));
    assign d_hit = done_en  & (done_idx  == IDX_W'(s));
    assign f_hit = free_en  & (free_idx  == IDX_W'(s));

    // Allocate beats retire: when full, the retiring slot is re-used in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= SLOT_FREE;
        gen_q <= 1'b0;
      end else if (a_hit) begin
        st_q  <= SLOT_PEND;
        gen_q <= alloc_gen;
      end else if (d_hit) begin
        st_q  <= SLOT_DONE;
      end else if (f_hit) begin
        st_q  <= SLOT_FREE;
      end
    end

    always_ff @(posedge clk) begin
      if (a_hit) hdr_q <= alloc_hdr;
      if (d_hit) begin
        sts_q <= done_status;
        dat_q <= done_data;
      end
    end

    assign state_vec[s] = st_q;
    assign gen_vec[s]   = gen_q;
    assign hdr_vec[s]   = hdr_q;
    assign sts_vec[s]   = sts_q;
    assign dat_vec[s]   = dat_q;
  end

  assign head_state  = e_slot_state'(state_vec[head_idx]);
  assign head_hdr    = t_cpl_hdr_info'(hdr_vec[head_idx]);
  assign head_status = sts_vec[head_idx];
  assign head_data   = dat_vec[head_idx];
  assign look_state  = e_slot_state'(state_vec[look_idx]);
  assign look_gen    = gen_vec[look_idx];

endmodule

// File: rtl/st2mm_cpl_tracker.sv
// In-order completion tracker for MMIO reads issued on AXI: allocates IDs,
// matches out-of-order read data, times out the head, emits completions in order.
module st2mm_cpl_tracker
  import st2mm_pkg::*;
#(
  parameter  int MMIO_DATA_WIDTH = 64,
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int TIMEOUT_CYCLES  = 4096,
  localparam int IDX_W           = $clog2(MAX_OUTSTANDING),
  localparam int ID_W            = IDX_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  t_cpl_hdr_info              req_hdr,
  output logic [ID_W-1:0]            req_id,
  input  logic                       rvalid,
  output logic                       rready,
  input  logic [ID_W-1:0]            rid,
  input  e_resp                      rresp,
  input  logic [MMIO_DATA_WIDTH-1:0] rdata,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output t_cpl_hdr_info              cpl_hdr,
  output logic [2:0]                 cpl_status,
  output logic [MMIO_DATA_WIDTH-1:0] cpl_data,
  output logic [15:0]                stray_rsp_cnt,
  output logic [15:0]                timeout_cnt
);

  localparam int               AGE_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES - 1);

  logic [ID_W-1:0]            head_q, tail_q, count;
  logic [AGE_W-1:0]           age_q;
  logic                       rdy_en_q;
  logic                       alloc, retire, match, stray, tmo, head_pend;
  e_slot_state                head_state, look_state;
  logic                       look_gen;
  t_cpl_hdr_info              head_hdr;
  logic [2:0]                 head_status;
  logic [MMIO_DATA_WIDTH-1:0] head_data;
  logic                       done_en;
  logic [IDX_W-1:0]           done_idx;
  logic [2:0]                 done_status;
  logic [MMIO_DATA_WIDTH-1:0] done_data;

  assign count     = tail_q - head_q;
  assign retire    = cpl_valid & cpl_ready;
  // A retire in this cycle frees a slot, so a full tracker may still accept.
  assign req_ready = rdy_en_q & ((count < ID_W'(MAX_OUTSTANDING)) | retire);
  assign req_id    = tail_q;
  assign rready    = rdy_en_q;
  assign alloc     = req_valid & req_ready;

  assign match     = rvalid & rready & (look_state == SLOT_PEND) & (look_gen == rid[IDX_W]);
  assign stray     = rvalid & rready & ~match;
  assign head_pend = (count != '0) & (head_state == SLOT_PEND);
  // The response port is shared: a timeout yields to any matched beat and
  // retries next cycle (age holds at its limit), so the head response wins.
  assign tmo       = head_pend & (age_q == AGE_MAX) & ~match;

  assign done_en     = match | tmo;
  assign done_idx    = match ? rid[IDX_W-1:0] : head_q[IDX_W-1:0];
  assign done_status = match ? resp_to_status(rresp) : CPL_CA;
  assign done_data   = match ? rdata : '1;

  st2mm_cpl_slot_ram #(
    .NUM_SLOTS (MAX_OUTSTANDING),
    .DATA_W    (MMIO_DATA_WIDTH)
  ) u_slot_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_en    (alloc),
    .alloc_idx   (tail_q[IDX_W-1:0]),
    .alloc_hdr   (req_hdr),
    .alloc_gen   (tail_q[IDX_W]),
    .done_en     (done_en),
    .done_idx    (done_idx),
    .done_status (done_status),
    .done_data   (done_data),
    .free_en     (retire),
    .free_idx    (head_q[IDX_W-1:0]),
    .head_idx    (head_q[IDX_W-1:0]),
    .head_state  (head_state),
    .head_hdr    (head_hdr),
    .head_status (head_status),
    .head_data   (head_data),
    .look_idx    (rid[IDX_W-1:0]),
    .look_state  (look_state),
    .look_gen    (look_gen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q      <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      age_q         <= '0;
      stray_rsp_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (alloc)  tail_q <= tail_q + 1'b1;
      if (retire) head_q <= head_q + 1'b1;
      if (retire || count == '0)                age_q <= '0;
      else if (head_pend && age_q != AGE_MAX)   age_q <= age_q + 1'b1;
      if (stray && stray_rsp_cnt != 16'hFFFF)   stray_rsp_cnt <= stray_rsp_cnt + 16'd1;
      if (tmo && timeout_cnt != 16'hFFFF)       timeout_cnt   <= timeout_cnt + 16'd1;
    end
  end

  // Completion output stage: loads from the head only while empty, so fields
  // hold under backpressure; a handshake empties it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_valid  <= 1'b0;
      cpl_hdr    <= '0;
      cpl_status <= '0;
      cpl_data   <= '0;
    end else if (retire) begin
      cpl_valid  <= 1'b0;
    end else if (!cpl_valid) begin
      cpl_valid  <= (count != '0) && (head_state == SLOT_DONE);
      cpl_hdr    <= head_hdr;
      cpl_status <= head_status;
      cpl_data   <= head_data;
    end
  end

endmodule
